regfile: RTL and testbench
==========================

// Module: regfile
// PURPOSE
//  32x32 MIPS32 general-purpose register file; responder for the two decode-stage read
//  ports (read-enable + address -> data) and for the write-back port from the MEM/WB register.
//  Reads are combinational, so the decode stage sees operands in the same cycle.
//  A post-reset sweep FSM clears every entry; init_done tells the pipeline when to start.
// PARAMETERS
//  DATA_W    32  width of each register
//  ADDR_W    5   register address width
//  NUM_REGS  32  entry count; must equal 2**ADDR_W
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       reset; synchronous, active-high
//  we         in   1       write enable from write-back
//  waddr      in   ADDR_W  write address
//  wdata      in   DATA_W  write data
//  re1        in   1       read port 1 enable
//  raddr1     in   ADDR_W  read port 1 address (rs)
//  rdata1     out  DATA_W  read port 1 data, combinational
//  re2        in   1       read port 2 enable
//  raddr2     in   ADDR_W  read port 2 address (rt)
//  rdata2     out  DATA_W  read port 2 data, combinational
//  init_done  out  1       high once the clear sweep is complete; registered
// BEHAVIOUR
//  - FSM states: INIT, RUN. Any clk edge with rst=1: state<=INIT, clr_ptr<=0, init_done<=0.
//  - rst is synchronous: its effect appears only at a clk edge, never asynchronously.
//  - While rst=1 the FSM holds in INIT with clr_ptr=0; the sweep starts on the first edge with rst=0.
//  - INIT, rst=0: each edge does regs[clr_ptr]<=0 and clr_ptr<=clr_ptr+1.
//  - INIT, clr_ptr==NUM_REGS-1: that edge clears the last entry, state<=RUN, init_done<=1.
//  - Sweep timing: init_done rises exactly NUM_REGS edges after rst deasserts (32 by default).
//  - clr_ptr is ADDR_W bits wide and must not wrap back into the sweep.
//  - Writes in INIT, or while rst=1, are dropped.
//  - RUN: on an edge with we=1 and waddr!=0, regs[waddr]<=wdata; writes to $0 are dropped.
//  - Reset mid-operation (rst=1 in RUN) restarts the full sweep; every earlier value is lost.
//  - Reset outputs: rdata1=rdata2=0 while rst=1; init_done=0 from the first edge with rst=1.
//  - Read port n, priority order:
//    1. rst=1 or init_done=0 -> 0
//    2. ren=0 -> 0
//    3. raddrn==0 -> 0 ($0 is hardwired)
//    4. bypass hit (see CONFIGURATION) -> wdata
//    5. otherwise -> regs[raddrn]
//  - Both read ports may name the same address, or the write address, in one cycle; the ports are independent.
//  - No reads or writes are out-of-range: NUM_REGS==2**ADDR_W.
// CONFIGURATION
//  - Macro: REGFILE_BYPASS_EN
//  - Defined: write-first forwarding. If init_done=1, we=1, waddr!=0 and waddr==raddrn with ren=1,
//    then rdata n = wdata in that same cycle (combinational). This resolves the
//    write-back-to-decode hazard at distance 3.
//  - Undefined: a read returns the pre-edge array value; the new value is visible from the next cycle.
//  - The write path and the FSM are identical in both builds.
// TESTING
//  - Sweep: pulse rst 2 cycles, then rst=0 -> init_done=0 for 31 edges, 1 on the 32nd edge;
//    all re=1 reads return 0 before and after.
//  - Write/read: RUN, write 0xDEADBEEF to r5 -> next cycle re1=1, raddr1=5 gives 0xDEADBEEF;
//    re1=0 gives 0.
//  - $0: we=1, waddr=0, wdata=0xFFFFFFFF -> rdata1/rdata2 for addr 0 stay 0, bypass build included.
//  - Same-cycle hazard: r7=0x11; write 0x22 to r7 while raddr2=7, re2=1 -> rdata2=0x22 with
//    REGFILE_BYPASS_EN, 0x11 without; 0x22 in both builds the next cycle.
//  - Mid-op reset: fill r1..r31 with index*3; assert rst 1 cycle -> init_done=0 and reads 0;
//    writes during INIT are dropped; after 32 edges r1..r31 read 0.
//  - Dual port: raddr1=raddr2=9 with r9=0x1234, re1=re2=1 -> both ports 0x1234;
//    re1=1, re2=0 -> rdata1=0x1234, rdata2=0.

Source files
------------

// File: rtl/regfile.sv
// 32x32 MIPS32 register file: two combinational read ports, one write-back port,
// and a post-reset clear sweep. Define REGFILE_BYPASS_EN for write-first forwarding.
module regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic              init_done
);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              hit1;
  logic              hit2;

  // The sweep pointer holds at the last entry once RUN is reached so it can never re-enter the sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      clr_ptr   <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          regs[clr_ptr] <= '0;
          if (clr_ptr == ADDR_W'(NUM_REGS - 1)) begin
            state     <= RUN;
            init_done <= 1'b1;
          end else begin
            clr_ptr <= clr_ptr + 1'b1;
          end
        end
        RUN: begin
          if (we && (waddr != '0)) regs[waddr] <= wdata;
        end
        default: state <= INIT;
      endcase
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign hit1 = we && (waddr == raddr1);
  assign hit2 = we && (waddr == raddr2);
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

  // $0 and the enable/reset gating take priority over any forwarding.
  always_comb begin
    rdata1 = '0;
    if (!rst && init_done && re1 && (raddr1 != '0))
      rdata1 = hit1 ? wdata : regs[raddr1];
  end

  always_comb begin
    rdata2 = '0;
    if (!rst && init_done && re2 && (raddr2 != '0))
      rdata2 = hit2 ? wdata : regs[raddr2];
  end

endmodule

// File: tb/tb_regfile.sv
// Randomized self-checking bench for regfile against an edge-counting array model.
module tb_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic        init_done;

  int testCount = 0;
  int failCount = 0;

  logic [31:0] modelRegs [32];
  int          edgesSinceReset = 0;

  regfile dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .init_done(init_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic modelReady();
    return edgesSinceReset >= 32;
  endfunction

  // Reads are zero until the register file is ready; otherwise the array value, or the in-flight write when forwarding.
  function automatic logic [31:0] expectedRead(input logic en, input logic [4:0] addr);
    if (rst || !modelReady() || !en || addr == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (we && waddr == addr) return wdata;
`endif
    return modelRegs[addr];
  endfunction

  task automatic applyStimulus(input logic aRst, input logic aWe, input logic [4:0] aWaddr,
                               input logic [31:0] aWdata, input logic aRe1, input logic [4:0] aRa1,
                               input logic aRe2, input logic [4:0] aRa2, input bit doCheck);
    rst = aRst; we = aWe; waddr = aWaddr; wdata = aWdata;
    re1 = aRe1; raddr1 = aRa1; re2 = aRe2; raddr2 = aRa2;
    #1;
    if (doCheck) begin
      checkOutput("rdata1", rdata1, expectedRead(re1, raddr1));
      checkOutput("rdata2", rdata2, expectedRead(re2, raddr2));
      checkOutput("init_done", {31'd0, init_done}, {31'd0, modelReady()});
    end
    @(posedge clk);
    if (rst) begin
      edgesSinceReset = 0;
      foreach (modelRegs[i]) modelRegs[i] = 32'd0;
    end else if (!modelReady()) begin
      edgesSinceReset++;
    end else if (we && waddr != 5'd0) begin
      modelRegs[waddr] = wdata;
    end
    @(negedge clk);
  endtask

  task automatic randomCycle(input logic aRst);
    applyStimulus(aRst, 1'($urandom_range(1)), 5'($urandom), $urandom,
                  1'($urandom_range(1)), 5'($urandom), 1'($urandom_range(1)), 5'($urandom), 1'b1);
  endtask

  task automatic readBoth(input logic [4:0] addr);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, addr, 1'b1, addr, 1'b1);
  endtask

  initial begin
    foreach (modelRegs[i]) modelRegs[i] = 32'd0;
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd3, 32'h55, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1);

    // Sweep: writes dropped, reads zero, init_done rises on the 32nd edge.
    for (int i = 0; i < 33; i++) randomCycle(1'b0);
    for (int a = 0; a < 32; a += 5) readBoth(5'(a));

    // Plain write then read; disabled port returns zero.
    applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b0, 5'd5, 1'b1);

    // $0 stays zero, including the same-cycle forwarding case.
    applyStimulus(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
    readBoth(5'd0);

    // Write-back/decode hazard on r7.
    applyStimulus(1'b0, 1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    applyStimulus(1'b0, 1'b1, 5'd7, 32'h22, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b1);

    // Dual port on r9.
    applyStimulus(1'b0, 1'b1, 5'd9, 32'h1234, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    readBoth(5'd9);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd9, 1'b1);

    // Fill, then reset mid-operation and confirm everything is cleared.
    for (int i = 1; i < 32; i++)
      applyStimulus(1'b0, 1'b1, 5'(i), 32'(i * 3), 1'b1, 5'(i - 1), 1'b1, 5'(i), 1'b1);
    for (int i = 1; i < 32; i += 6) readBoth(5'(i));
    applyStimulus(1'b1, 1'b1, 5'd4, 32'hAAAA, 1'b1, 5'd4, 1'b1, 5'd6, 1'b1);
    for (int i = 0; i < 32; i++) randomCycle(1'b0);
    for (int i = 1; i < 32; i++) readBoth(5'(i));

    // Long random run with occasional resets.
    for (int i = 0; i < 400; i++) randomCycle(1'($urandom_range(99) == 0));

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
